// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, default
// parameters and the oversample tick positions used for bit sampling.
package uart_pkg;

  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_STOP_TICKS   = 16;
  localparam int DEF_BAUD_DIVISOR = 651;  // 100 MHz / (9600 x 16)

  // Oversample tick positions within one 16-tick bit period
  localparam logic [3:0] MID_BIT_TICK = 4'd7;
  localparam logic [3:0] END_BIT_TICK = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/baud_rate_generator.sv
// Free-running divider producing a one-clock oversample tick every
// BAUD_DIVISOR clocks.
module baud_rate_generator
  import uart_pkg::*;
#(
  parameter int BAUD_DIVISOR = DEF_BAUD_DIVISOR
) (
  input  logic clk_100Mhz,
  input  logic reset,
  output logic tick
);

  localparam int CW = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampling UART receiver: synchronizes rx, samples mid-bit, and emits
// a registered done pulse per good frame or a framing-error pulse per bad stop.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int STOP_TICKS   = DEF_STOP_TICKS,
  parameter int BAUD_DIVISOR = DEF_BAUD_DIVISOR
) (
  input  logic                 clk_100Mhz,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_done_tick,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [NW-1:0] LAST_BIT  = NW'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_TICKS - 1);

  logic                 rx_meta_q, rx_s_q;
  logic                 rx_s;
  logic                 s_tick;
  rx_state_e            state_q, state_d;
  logic [3:0]           s_cnt_q, s_cnt_d;
  logic [NW-1:0]        n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_end;

  baud_rate_generator #(
    .BAUD_DIVISOR(BAUD_DIVISOR)
  ) u_baud (
    .clk_100Mhz(clk_100Mhz),
    .reset     (reset),
    .tick      (s_tick)
  );

  // Synchronizer flops reset to the idle line level so no false start is seen
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign rx_s = rx_s_q;

  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_cnt_d = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_cnt_q == MID_BIT_TICK) begin
            // A start bit that is high again at its midpoint was a glitch
            if (!rx_s) begin
              state_d = ST_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == END_BIT_TICK) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == LAST_BIT) begin
              state_d = ST_STOP;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulses are decided on the last stop tick and registered, so they appear
  // one clock later together with the freshly loaded data word.
  always_comb begin
    stop_end = (state_q == ST_STOP) && s_tick && (s_cnt_q == STOP_LAST);
    done_d   = stop_end && rx_s;
    ferr_d   = stop_end && !rx_s;
    data_d   = done_d ? shift_q : data_q;
  end

  assign rx_data_out   = data_q;
  assign rx_done_tick  = done_q;
  assign framing_error = ferr_q;
  assign rx_busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame.
REQ-002 Parameter STOP_TICKS, default 16: oversample ticks in the stop bit (16 = 1 stop bit).
REQ-003 Parameter BAUD_DIVISOR, default 651: clocks per oversample tick (100 MHz / (9600 x 16)).
REQ-004 clk_100Mhz  input  1  system clock; all state is updated on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 rx_data_out  output  DATA_BITS  last correctly framed byte; connects directly to FIFO write_data_in.
REQ-008 rx_done_tick  output  1  one-cycle pulse when rx_data_out is updated; connects directly to FIFO write_to_fifo.
REQ-009 framing_error  output  1  one-cycle pulse when a frame's stop bit samples low.
REQ-010 rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value (rx_s).
REQ-012 The tick generator SHALL count 0..BAUD_DIVISOR-1 free-running, pulse s_tick for one clock at count BAUD_DIVISOR-1, then wrap to 0.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP, a 4-bit tick counter s_cnt and a bit counter n_cnt of width clog2(DATA_BITS).
REQ-014 IDLE: when rx_s=0, go to START and clear s_cnt; otherwise stay.
REQ-015 START: on s_tick with s_cnt=7 (mid start bit), if rx_s=0 go to DATA and clear s_cnt and n_cnt; if rx_s=1 treat as a glitch and return to IDLE with no output pulse; on other s_ticks increment s_cnt.
REQ-016 DATA: on s_tick with s_cnt=15, shift rx_s into the MSB of the shift register (LSB-first line order), clear s_cnt, and go to STOP if n_cnt=DATA_BITS-1, else increment n_cnt; on other s_ticks increment s_cnt.
REQ-017 STOP: on s_tick with s_cnt=STOP_TICKS-1, return to IDLE; if rx_s=1, load rx_data_out from the shift register and pulse rx_done_tick; if rx_s=0, pulse framing_error and leave rx_data_out unchanged; on other s_ticks increment s_cnt.
REQ-018 rx_done_tick and framing_error SHALL be registered, high for exactly one clock, in the cycle after the deciding s_tick, and never high together.
REQ-019 rx_data_out SHALL be stable whenever rx_done_tick is high and SHALL hold until the next good frame.
REQ-020 A new falling edge on rx_s SHALL be accepted in IDLE on the clock after the STOP-to-IDLE transition; back-to-back frames SHALL not be lost.
REQ-021 The block SHALL not apply backpressure; a byte arriving while the downstream FIFO is full is dropped by the FIFO.
REQ-022 rx_s=0 held continuously (break) SHALL produce framing_error once per frame time, then restart START from IDLE.

Reset
REQ-023 On reset: state=IDLE, s_cnt=0, n_cnt=0, shift register=0, rx_data_out=0, rx_done_tick=0, framing_error=0, rx_busy=0, tick counter=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception resumes at the next falling edge after reset release.

Structure
REQ-025 Shared package uart_pkg SHALL hold the FSM state encoding, the default DATA_BITS, STOP_TICKS and BAUD_DIVISOR, and the mid-bit constant 7 / end-of-bit constant 15.
REQ-026 The tick generator SHALL be the sub-module baud_rate_generator (parameter BAUD_DIVISOR; ports clk_100Mhz, reset, tick). The FSM stays in uart_receiver.

Verification (BAUD_DIVISOR=4, so 1 bit = 64 clocks)
REQ-027 Frame 0xA5 with valid stop bit -> rx_data_out=8'hA5, exactly one rx_done_tick, framing_error stays 0.
REQ-028 Frames 0x00, 0xFF and 0x3C back-to-back with no idle gap -> three rx_done_ticks with values 00, FF, 3C in order.
REQ-029 rx low for 20 clocks, then high -> returns to IDLE, no pulses, rx_data_out unchanged.
REQ-030 Frame 0x5A with stop bit driven low -> one framing_error pulse, no rx_done_tick, rx_data_out keeps its previous value.
REQ-031 Reset asserted during DATA bit 4 of a frame -> all outputs 0 at once; next clean frame 0x81 -> rx_data_out=8'h81.
REQ-032 Connected to the 8-entry FIFO, send 9 frames 0x01..0x09 -> FIFO full, packed read_data_out=64'h0807060504030201, ninth byte dropped.
